// File: rtl/rob_complete_arbiter.sv
// ROB completion-port arbiter: one holding buffer per unit, round-robin grant (oldest-first with ROB_ARB_OLDEST_FIRST_EN).
// Latency: request accepted at edge N is presented on complete_* in cycle N+1; no bypass path.
// Backpressure: req_ready_o high while the buffer is empty or being granted this cycle; all low during flush.

package params_pkg;
    localparam int ROB_ENTRIES     = 16;
    localparam int ROB_ENTRY_WIDTH = 4;
    localparam int DATA_WIDTH      = 32;
    localparam int ADDR_WIDTH      = 32;

    typedef enum logic [3:0] {
        EXC_INSTR_MISALIGNED   = 4'd0,
        EXC_INSTR_ACCESS_FAULT = 4'd1,
        EXC_ILLEGAL_INSTR      = 4'd2,
        EXC_BREAKPOINT         = 4'd3,
        EXC_LOAD_MISALIGNED    = 4'd4,
        EXC_LOAD_ACCESS_FAULT  = 4'd5,
        EXC_STORE_MISALIGNED   = 4'd6,
        EXC_STORE_ACCESS_FAULT = 4'd7,
        EXC_ECALL_U            = 4'd8,
        EXC_ECALL_S            = 4'd9,
        EXC_ECALL_M            = 4'd11,
        EXC_INSTR_PAGE_FAULT   = 4'd12,
        EXC_LOAD_PAGE_FAULT    = 4'd13,
        EXC_STORE_PAGE_FAULT   = 4'd15
    } excpt_cause_t;
endpackage

module rob_complete_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int ROB_ENTRIES     = params_pkg::ROB_ENTRIES,
    parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
    parameter int DATA_WIDTH      = params_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic [ROB_ENTRY_WIDTH-1:0]                  rob_head_i,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [NUM_REQ-1:0][ROB_ENTRY_WIDTH-1:0]     req_idx_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]          req_data_i,
    input  logic [NUM_REQ-1:0]                          req_excp_valid_i,
    input  params_pkg::excpt_cause_t [NUM_REQ-1:0]      req_excp_cause_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]          req_excp_tval_i,
    output logic                                        complete_valid_o,
    output logic [ROB_ENTRY_WIDTH-1:0]                  complete_idx_o,
    output logic [DATA_WIDTH-1:0]                       complete_data_o,
    output logic                                        complete_excp_valid_o,
    output params_pkg::excpt_cause_t                    complete_excp_cause_o,
    output logic [ADDR_WIDTH-1:0]                       complete_excp_tval_o,
    output logic [NUM_REQ-1:0]                          grant_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ROB_ENTRY_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]      data;
        logic                       excp;
        params_pkg::excpt_cause_t   cause;
        logic [ADDR_WIDTH-1:0]      tval;
    } entry_t;

    entry_t [NUM_REQ-1:0] buf_q;
    logic   [NUM_REQ-1:0] occ_q;
    logic   [PTR_W-1:0]   rr_ptr_q;

    logic                 any_occ;
    logic                 grant_vld;
    logic   [PTR_W-1:0]   grant_idx;
    logic   [PTR_W-1:0]   slot;
    entry_t               win;

    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] p, input int i);
        int k;
        k = int'(p) + i;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        return PTR_W'(k);
    endfunction

`ifdef ROB_ARB_OLDEST_FIRST_EN
    localparam logic [ROB_ENTRY_WIDTH-1:0] AGE_MASK = ROB_ENTRY_WIDTH'(ROB_ENTRIES - 1);
    logic [ROB_ENTRY_WIDTH-1:0] age;
    logic [ROB_ENTRY_WIDTH-1:0] best_age;
`else
    logic unused_head;
    assign unused_head = ^{rob_head_i, ROB_ENTRIES[0]};
`endif

    // Scan in RR order from the pointer; strict compare keeps RR order as the age tie-break.
    always_comb begin
        any_occ   = 1'b0;
        grant_idx = '0;
        slot      = '0;
`ifdef ROB_ARB_OLDEST_FIRST_EN
        age       = '0;
        best_age  = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = rr_slot(rr_ptr_q, i);
`ifdef ROB_ARB_OLDEST_FIRST_EN
            age = (buf_q[slot].idx - rob_head_i) & AGE_MASK;
            if (occ_q[slot] && (!any_occ || age < best_age)) begin
                any_occ   = 1'b1;
                grant_idx = slot;
                best_age  = age;
            end
`else
            if (occ_q[slot] && !any_occ) begin
                any_occ   = 1'b1;
                grant_idx = slot;
            end
`endif
        end
    end

    assign grant_vld = any_occ && !flush_i;

    always_comb begin
        grant_o = '0;
        if (grant_vld) grant_o[grant_idx] = 1'b1;
    end

    assign win                   = grant_vld ? buf_q[grant_idx] : '0;
    assign complete_valid_o      = grant_vld;
    assign complete_idx_o        = win.idx;
    assign complete_data_o       = win.data;
    assign complete_excp_valid_o = win.excp;
    assign complete_excp_cause_o = win.cause;
    assign complete_excp_tval_o  = win.tval;

    assign req_ready_o = flush_i ? '0 : (~occ_q | grant_o);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            occ_q    <= '0;
            buf_q    <= '0;
            rr_ptr_q <= '0;
        end else if (flush_i) begin
            occ_q    <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    occ_q[k] <= 1'b1;
                    buf_q[k] <= '{idx:   req_idx_i[k],
                                  data:  req_data_i[k],
                                  excp:  req_excp_valid_i[k],
                                  cause: req_excp_cause_i[k],
                                  tval:  req_excp_tval_i[k]};
                end else if (grant_o[k]) begin
                    occ_q[k] <= 1'b0;
                end
            end
            if (grant_vld)
                rr_ptr_q <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

`ifndef SYNTHESIS
    logic dup_idx;
    always_comb begin
        dup_idx = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = i + 1; j < NUM_REQ; j++)
                if (occ_q[i] && occ_q[j] && buf_q[i].idx == buf_q[j].idx) dup_idx = 1'b1;
    end

    a_no_dup_idx: assert property (@(posedge clk_i) disable iff (!rst_i) !dup_idx)
        else $error("two requesters hold the same ROB index");
`endif

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Bench for rob_complete_arbiter: directed stimulus, expected completions queued, separate monitor pops and compares.
// Latency: checks at negedge; inputs change 1ns after posedge.
// Backpressure: ready vectors checked against hand tables in contention/flush.

module tb_rob_complete_arbiter;
    import params_pkg::*;

    typedef struct packed {
        logic [2:0]  grant;
        logic [3:0]  idx;
        logic [31:0] data;
        logic        excp;
        logic [3:0]  cause;
        logic [31:0] tval;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [3:0]               rob_head;
    logic [2:0]               req_valid;
    logic [2:0]               req_ready;
    logic [2:0][3:0]          req_idx;
    logic [2:0][31:0]         req_data;
    logic [2:0]               req_excp;
    excpt_cause_t [2:0]       req_cause;
    logic [2:0][31:0]         req_tval;
    logic                     cpl_valid;
    logic [3:0]               cpl_idx;
    logic [31:0]              cpl_data;
    logic                     cpl_excp;
    excpt_cause_t             cpl_cause;
    logic [31:0]              cpl_tval;
    logic [2:0]               grant;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rob_complete_arbiter #(.NUM_REQ(3)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .flush_i               (flush),
        .rob_head_i            (rob_head),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_idx_i             (req_idx),
        .req_data_i            (req_data),
        .req_excp_valid_i      (req_excp),
        .req_excp_cause_i      (req_cause),
        .req_excp_tval_i       (req_tval),
        .complete_valid_o      (cpl_valid),
        .complete_idx_o        (cpl_idx),
        .complete_data_o       (cpl_data),
        .complete_excp_valid_o (cpl_excp),
        .complete_excp_cause_o (cpl_cause),
        .complete_excp_tval_o  (cpl_tval),
        .grant_o               (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] g, input logic [3:0] idx, input logic [31:0] d,
                            input logic e, input logic [3:0] c, input logic [31:0] t);
        exp_q.push_back('{grant: g, idx: idx, data: d, excp: e, cause: c, tval: t});
    endtask

    task automatic set_req(input int u, input logic [3:0] idx, input logic [31:0] d,
                           input logic e, input excpt_cause_t c, input logic [31:0] t);
        req_valid[u] = 1'b1;
        req_idx[u]   = idx;
        req_data[u]  = d;
        req_excp[u]  = e;
        req_cause[u] = c;
        req_tval[u]  = t;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_idx   = '0;
        req_data  = '0;
        req_excp  = '0;
        req_tval  = '0;
        for (int u = 0; u < 3; u++) req_cause[u] = EXC_INSTR_MISALIGNED;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] cont_data(input int u, input int n);
        return 32'hC000_0000 | 32'(u << 8) | 32'(n);
    endfunction

    // Monitor: every presented completion must match the head of the expected queue.
    always @(negedge clk) begin
        if (cpl_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cpl got idx=%0h data=%0h grant=%b exp=none", cpl_idx, cpl_data, grant);
            end else begin
                exp_t e;
                exp_t a;
                e = exp_q.pop_front();
                a = '{grant: grant, idx: cpl_idx, data: cpl_data, excp: cpl_excp,
                      cause: cpl_cause, tval: cpl_tval};
                if (a !== e) begin
                    errors++;
                    $display("FAIL cpl got g=%b idx=%0h d=%0h x=%b c=%0h t=%0h exp g=%b idx=%0h d=%0h x=%b c=%0h t=%0h",
                             a.grant, a.idx, a.data, a.excp, a.cause, a.tval,
                             e.grant, e.idx, e.data, e.excp, e.cause, e.tval);
                end
            end
        end else begin
            checks++;
            if (grant !== 3'b000 || cpl_idx !== 4'h0 || cpl_data !== 32'h0 || cpl_excp !== 1'b0 || cpl_tval !== 32'h0) begin
                errors++;
                $display("FAIL idle_zero got g=%b idx=%0h d=%0h x=%b t=%0h exp all zero",
                         grant, cpl_idx, cpl_data, cpl_excp, cpl_tval);
            end
        end
    end

    logic [2:0] exp_rdy [10] = '{3'b111, 3'b001, 3'b010, 3'b100, 3'b001,
                                 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        int         n [3];
        logic [2:0] acc;

        rst_n    = 1'b0;
        flush    = 1'b0;
        rob_head = '0;
        clear_reqs();

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(cpl_valid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'b111);

        // Single unit, back-to-back idx 5,6,7
        @(posedge clk); #1;
        set_req(0, 4'd5, 32'hDEAD_BEEF, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        push_exp(3'b001, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        chk("no_bypass", 64'(cpl_valid), 64'd0);
        chk("b2b_rdy5", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        set_req(0, 4'd6, 32'h0000_0606, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        push_exp(3'b001, 4'd6, 32'h0000_0606, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        chk("lat_idx", 64'({cpl_valid, cpl_idx}), 64'h15);
        chk("b2b_rdy6", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        set_req(0, 4'd7, 32'h0000_0707, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        push_exp(3'b001, 4'd7, 32'h0000_0707, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        chk("b2b_rdy7", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1 clear_reqs();
        wait_drain("drain_single");

        // Contention from pointer 0: grants rotate 001,010,100
        apply_reset();
        for (int nn = 0; nn < 4; nn++)
            for (int u = 0; u < 3; u++)
                push_exp(3'(1 << u), 4'(u * 5 + nn), cont_data(u, nn), 1'b0, 4'd0, 32'h0);
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) begin
            n[u] = 0;
            set_req(u, 4'(u * 5), cont_data(u, 0), 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("cont_rdy%0d", c), 64'(req_ready), 64'(exp_rdy[c]));
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) begin
                if (acc[u]) begin
                    n[u]++;
                    if (n[u] < 4)
                        set_req(u, 4'(u * 5 + n[u]), cont_data(u, n[u]), 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
                    else
                        req_valid[u] = 1'b0;
                end
            end
        end
        clear_reqs();
        wait_drain("drain_cont");

        // Flush with buffers 0 and 2 occupied and req1 arriving
        @(posedge clk); #1;
        set_req(0, 4'd2, 32'h0000_0A0A, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        set_req(2, 4'd3, 32'h0000_0B0B, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        @(posedge clk); #1;
        clear_reqs();
        flush = 1'b1;
        set_req(1, 4'd9, 32'h0000_9999, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        @(negedge clk);
        chk("flush_vld", 64'(cpl_valid), 64'd0);
        chk("flush_grant", 64'(grant), 64'd0);
        chk("flush_rdy", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        clear_reqs();
        @(negedge clk);
        chk("post_flush_vld", 64'(cpl_valid), 64'd0);
        chk("post_flush_rdy", 64'(req_ready), 64'b111);
        repeat (3) @(posedge clk);

        // Exception result passes through unmodified
        @(posedge clk); #1;
        set_req(2, 4'd3, 32'h0, 1'b1, EXC_LOAD_PAGE_FAULT, 32'h0000_1000);
        push_exp(3'b100, 4'd3, 32'h0, 1'b1, 4'd13, 32'h0000_1000);
        @(posedge clk); #1 clear_reqs();
        wait_drain("drain_excp");

        // Asynchronous reset mid-cycle with two buffers occupied
        @(posedge clk); #1;
        set_req(0, 4'd4, 32'h0000_0404, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        set_req(1, 4'd6, 32'h0000_0606, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        @(posedge clk); #1;
        clear_reqs();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(cpl_valid), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 64'(req_ready), 64'b111);
        repeat (4) @(posedge clk);

        // Head at 14: idx 15 is older than idx 1
        @(posedge clk); #1;
        rob_head = 4'd14;
        set_req(0, 4'd1, 32'h0000_1111, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
        set_req(1, 4'd15, 32'h0000_FFFF, 1'b0, EXC_INSTR_MISALIGNED, 32'h0);
`ifdef ROB_ARB_OLDEST_FIRST_EN
        push_exp(3'b010, 4'd15, 32'h0000_FFFF, 1'b0, 4'd0, 32'h0);
        push_exp(3'b001, 4'd1, 32'h0000_1111, 1'b0, 4'd0, 32'h0);
`else
        push_exp(3'b001, 4'd1, 32'h0000_1111, 1'b0, 4'd0, 32'h0);
        push_exp(3'b010, 4'd15, 32'h0000_FFFF, 1'b0, 4'd0, 32'h0);
`endif
        @(posedge clk); #1 clear_reqs();
        wait_drain("drain_age");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_complete_arbiter.md
Name: rob_complete_arbiter

Overview:
- Shares the reorder buffer's single completion write port (complete valid/idx/data/excp) between NUM_REQ functional units: ALU, MUL/DIV, LSU by default.
- Each requester gets a one-entry holding buffer with valid/ready handshake. Buffers are arbitrated round-robin; the winner drives the ROB completion inputs combinationally.
- Sits between the execute units and the reorder buffer. Honours pipeline flush.

Parameters:
NUM_REQ, 3, number of completing functional units (2..8)
ROB_ENTRIES, params_pkg::ROB_ENTRIES, ROB depth (power of two)
ROB_ENTRY_WIDTH, params_pkg::ROB_ENTRY_WIDTH, ROB index width
DATA_WIDTH, params_pkg::DATA_WIDTH, result width
ADDR_WIDTH, params_pkg::ADDR_WIDTH, exception tval width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  pipeline flush from ROB
rob_head_i  in  ROB_ENTRY_WIDTH  current ROB head index (used only with optional feature)
req_valid_i  in  NUM_REQ  per-unit completion request
req_ready_o  out  NUM_REQ  per-unit accept
req_idx_i  in  NUM_REQ x ROB_ENTRY_WIDTH  ROB index of completing instr
req_data_i  in  NUM_REQ x DATA_WIDTH  result
req_excp_valid_i  in  NUM_REQ  exception raised
req_excp_cause_i  in  NUM_REQ x excpt_cause_t  exception cause
req_excp_tval_i  in  NUM_REQ x ADDR_WIDTH  exception tval
complete_valid_o  out  1  to ROB instr_complete_valid
complete_idx_o  out  ROB_ENTRY_WIDTH  to ROB instr_complete_idx
complete_data_o  out  DATA_WIDTH  to ROB instr_complete_data
complete_excp_valid_o  out  1  to ROB excp valid
complete_excp_cause_o  out  excpt_cause_t  exception cause
complete_excp_tval_o  out  ADDR_WIDTH  exception tval
grant_o  out  NUM_REQ  one-hot winner, zero when idle

Behaviour:
- Reset (rst_i low, async): all buffers empty, RR pointer = 0. complete_* outputs and grant_o = 0; req_ready_o = all-ones once reset deasserts.
- Holding buffer k: fields occ, idx, data, excp, cause, tval.
- Handshake: transfer on req_valid_i[k] && req_ready_o[k].
  - req_ready_o[k] = !flush_i && (!occ[k] || grant_o[k]).
  - A transfer loads the buffer at the clock edge.
  - req_* must be held stable while valid && !ready.
- Latency: accepted at edge N, presented on complete_* in cycle N+1 at the earliest. No bypass from req_* to complete_*.
- Arbitration:
  - Among occupied buffers, choose the first at or after RR pointer p, scanning p, p+1 … with wrap mod NUM_REQ.
  - After a grant to k, p <= (k+1) mod NUM_REQ; p holds when there is no grant.
  - Exactly one grant per cycle.
  - A granted buffer empties at the edge unless refilled in the same cycle, giving one completion per requester per cycle sustained when alone.
- Outputs are combinational from the granted buffer. All complete_* fields are 0 when there is no grant.
- Flush (flush_i = 1):
  - grant_o = 0, complete_valid_o = 0, req_ready_o = 0.
  - All occ cleared at the edge; incoming requests in that cycle are dropped.
  - RR pointer unchanged.
- Exception results go through the same arbitration as normal results; excp/cause/tval pass through unmodified.
- Duplicate idx across requesters is illegal. An SVA assertion flags it under ifndef SYNTHESIS.
- Reset asserted mid-operation discards buffered completions immediately.

Optional Feature:
ROB_ARB_OLDEST_FIRST_EN
- Defined: the winner is the occupied buffer with minimum age = (idx - rob_head_i) mod ROB_ENTRIES, so the ROB head completes first. Ties are broken by RR order; p updates as in the base scheme.
- Undefined: pure round-robin; rob_head_i is ignored but the port stays present.

Test Plan:
- Reset: assert rst_i low asynchronously mid-cycle with 2 buffers occupied -> complete_valid_o = 0 and grant_o = 0 immediately; after release req_ready_o = 3'b111 and no stale completion appears.
- Single unit: req0 valid, idx = 5, data = 0xDEADBEEF in cycle 1 -> cycle 2 complete_valid_o = 1, idx = 5, data = 0xDEADBEEF, grant_o = 001. Back-to-back idx 5, 6, 7 -> one completion per cycle, ready never drops.
- Contention: all 3 units valid continuously from cycle 1 -> grant_o sequence 001, 010, 100, 001…; each req_ready_o is high only in its granted cycle after fill.
- Flush: buffers 0 and 2 occupied, flush_i = 1 for one cycle with req1 valid -> that cycle complete_valid_o = 0 and req_ready_o = 000; next cycle all buffers empty and req1's request is not delivered.
- Exception: req2 idx = 3, excp = 1, cause = load page fault, tval = 0x1000 -> next cycle complete_excp_valid_o = 1 with the same cause/tval and idx = 3.
- Oldest-first (macro defined): ROB_ENTRIES = 16, rob_head_i = 14, buffers hold idx 1 (req0) and 15 (req1) -> grant req1 (idx 15) first, then req0. Macro undefined with the same setup and p = 0 -> req0 first.
